// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared receive-path types and constants
package usb_rx_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, ERR, DONE} rcv_state_t;
  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam int STUFF_LIMIT = 6;
  localparam int DEF_MAX_BYTES = 64;
endpackage

// File: rtl/rx_unstuffer.sv
// rx_unstuffer: counts consecutive ones and flags the stuff bit that follows six of them
module rx_unstuffer
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic bit_in,
  output logic bit_keep,
  output logic stuff_err,
  output logic stuff_pend
);
  logic [2:0] ones_cnt;
  assign stuff_pend = ones_cnt == 3'(STUFF_LIMIT);
  assign bit_keep = en && !stuff_pend;
  assign stuff_err = en && stuff_pend && bit_in;
  // load primes the run with the final SYNC one; a stuff bit or a zero restarts the run
  always_ff @(posedge clk or posedge rst)
    if (rst) ones_cnt <= '0;
    else if (load) ones_cnt <= 3'd1;
    else if (en) ones_cnt <= (bit_in && !stuff_pend) ? ones_cnt + 3'd1 : '0;
endmodule

// File: rtl/rcv_controller.sv
// rcv_controller: USB full-speed receive sequencer from decoded bits to FIFO bytes
module rcv_controller
  import usb_rx_pkg::*;
#(
  parameter int MAX_BYTES = DEF_MAX_BYTES,
  parameter int BCNT_W = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              dp_in,
  input  logic              dm_in,
  input  logic              d_orig,
  input  logic              dec_error,
  input  logic              end_packet,
  input  logic              fifo_full,
  output logic              dec_restart,
  output logic              w_enable,
  output logic [7:0]        rcv_data,
  output logic              rcving,
  output logic              packet_done,
  output logic              r_error,
  output logic [BCNT_W-1:0] byte_cnt
);
  rcv_state_t state;
  logic bit_valid;
  logic [7:0] shift, sh_n;
  logic [2:0] bit_cnt;
  logic bit_keep, stuff_err, stuff_pend;
  logic sync_ok, last, wr_ok, wr_fail, eop_ok, bad;

  rx_unstuffer u_unstuff (
    .clk        (clk),
    .rst        (rst),
    .load       (sync_ok),
    .en         (state == DATA && bit_valid),
    .bit_in     (d_orig),
    .bit_keep   (bit_keep),
    .stuff_err  (stuff_err),
    .stuff_pend (stuff_pend)
  );

  // byte completion and EOP checks account for a bit consumed in the same cycle
  always_comb begin
    sh_n = {d_orig, shift[7:1]};
    sync_ok = state == SYNC && bit_valid && bit_cnt == 3'd7 && sh_n == SYNC_PATTERN;
    last = bit_keep && bit_cnt == 3'd7;
    wr_ok = last && !fifo_full && byte_cnt != BCNT_W'(MAX_BYTES);
    wr_fail = last && !wr_ok;
    eop_ok = (bit_keep ? bit_cnt == 3'd7 : bit_cnt == 3'd0) && (!stuff_pend || bit_valid)
             && (byte_cnt != '0 || wr_ok);
    bad = dec_error || stuff_err || wr_fail || (end_packet && !eop_ok);
  end

  // packet sequencer; a completing byte is always written before an EOP is judged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bit_valid <= 1'b0;
      shift <= '0;
      bit_cnt <= '0;
      dec_restart <= 1'b0;
      w_enable <= 1'b0;
      rcv_data <= '0;
      rcving <= 1'b0;
      packet_done <= 1'b0;
      r_error <= 1'b0;
      byte_cnt <= '0;
    end else begin
      bit_valid <= sample_en && (dp_in != dm_in);
      w_enable <= 1'b0;
      dec_restart <= 1'b0;
      packet_done <= 1'b0;
      case (state)
        IDLE: if (bit_valid && !d_orig) begin
          shift <= '0;
          bit_cnt <= 3'd1;
          state <= SYNC;
          rcving <= 1'b1;
          r_error <= 1'b0;
          byte_cnt <= '0;
        end
        SYNC: if (dec_error) begin
          r_error <= 1'b1;
          state <= ERR;
        end else if (end_packet) begin
          r_error <= 1'b1;
          state <= DONE;
        end else if (bit_valid) begin
          shift <= sh_n;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= sync_ok ? DATA : IDLE;
            dec_restart <= !sync_ok;
            rcving <= sync_ok;
          end
        end
        DATA: begin
          if (bit_keep) begin
            shift <= sh_n;
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (wr_ok) begin
            w_enable <= 1'b1;
            rcv_data <= sh_n;
            byte_cnt <= byte_cnt + BCNT_W'(1);
          end
          if (bad) r_error <= 1'b1;
          if (end_packet && !dec_error) begin
            packet_done <= !bad;
            state <= DONE;
          end else if (bad) state <= ERR;
        end
        ERR: if (end_packet) state <= DONE;
        DONE: begin
          dec_restart <= 1'b1;
          rcving <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
